// File: rtl/logic_unit_pkg.sv
// Shared opcode and FSM-state definitions for the round-robin logic-unit arbiter.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after ptr_i, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] grant_o,
    output logic          any_o
);

    int idx;

    // Scan from the farthest offset down so the nearest requester after ptr_i is assigned last.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr_i) + k) % N;
            if (req_i[idx]) begin
                grant_o = IW'(idx);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one bitwise logic unit among NUM_REQ requesters; one transaction in flight at a time.
//  state    | meaning
//  ST_IDLE  | waiting for any req_valid; winner latched on exit
//  ST_GRANT | req_ready pulsed to winner; operands captured at end of cycle
//  ST_EXEC  | result computed and registered onto the response port
//  ST_RESP  | rsp_valid held until rsp_ready, then pointer moves to the winner
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*3-1:0]     req_op,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IW-1:0]            rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    state_t               state_q;
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        gnt_q;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [NUM_REQ-1:0]   req_ready_q;
    logic                 rsp_valid_q;
    logic [IW-1:0]        rsp_id_q;
    logic [WIDTH-1:0]     rsp_data_q;
    logic                 rsp_err_q;

    logic [IW-1:0]        win;
    logic                 win_any;
    logic [WIDTH-1:0]     res_d;
    logic                 err_d;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (win),
        .any_o   (win_any)
    );

    always_comb begin
        res_d = '0;
        err_d = 1'b0;
        case (op_q)
            OP_AND:  res_d = a_q & b_q;
            OP_OR:   res_d = a_q | b_q;
            OP_NOT:  res_d = ~a_q;
            OP_NAND: res_d = ~(a_q & b_q);
            OP_NOR:  res_d = ~(a_q | b_q);
            OP_XOR:  res_d = a_q ^ b_q;
            OP_XNOR: res_d = ~(a_q ^ b_q);
            OP_RSVD: err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IW'(NUM_REQ - 1);
            gnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_any) begin
                        gnt_q       <= win;
                        req_ready_q <= ONE_HOT0 << win;
                        state_q     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Capture regardless of req_valid so a dropped request still completes.
                    op_q        <= req_op[int'(gnt_q)*3 +: 3];
                    a_q         <= req_a[int'(gnt_q)*WIDTH +: WIDTH];
                    b_q         <= req_b[int'(gnt_q)*WIDTH +: WIDTH];
                    req_ready_q <= '0;
                    state_q     <= ST_EXEC;
                end
                ST_EXEC: begin
                    rsp_data_q  <= res_d;
                    rsp_err_q   <= err_d;
                    rsp_id_q    <= gnt_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ptr_q       <= gnt_q;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: opcode table, fairness, backpressure, reset cases.
module tb_logic_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [11:0] req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    typedef struct {
        int         id;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] data;
        logic       err;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*id +: 3] = op;
        req_a[8*id +: 8]  = a;
        req_b[8*id +: 8]  = b;
        req_valid[id]     = 1'b1;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the bubble cycle.
    task automatic run_txn(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_d, input logic exp_e);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        drive_req(id, op, a, b);
        @(negedge clk);
        chk("txn_req_ready", 32'(req_ready), 32'(oh));
        req_valid[id] = 1'b0;
        @(negedge clk);
        chk("txn_rsp_early", 32'(rsp_valid), 32'(0));
        chk("txn_busy", 32'(busy), 32'(1));
        @(negedge clk);
        chk("txn_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("txn_rsp_id", 32'(rsp_id), 32'(id));
        chk("txn_rsp_data", 32'(rsp_data), 32'(exp_d));
        chk("txn_rsp_err", 32'(rsp_err), 32'(exp_e));
        @(negedge clk);
        chk("txn_bubble", 32'(rsp_valid), 32'(0));
    endtask

    initial begin
        int nresp;
        int last_t;
        logic [1:0] exp_id;

        tbl[0] = '{0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
        tbl[1] = '{0, 3'd1, 8'hF0, 8'h3C, 8'hFC, 1'b0};
        tbl[2] = '{0, 3'd2, 8'hF0, 8'h3C, 8'h0F, 1'b0};
        tbl[3] = '{0, 3'd3, 8'hF0, 8'h3C, 8'hCF, 1'b0};
        tbl[4] = '{0, 3'd4, 8'hF0, 8'h3C, 8'h03, 1'b0};
        tbl[5] = '{0, 3'd5, 8'hF0, 8'h3C, 8'hCC, 1'b0};
        tbl[6] = '{0, 3'd6, 8'hF0, 8'h3C, 8'h33, 1'b0};
        tbl[7] = '{2, 3'd7, 8'hAA, 8'h55, 8'h00, 1'b1};
        tbl[8] = '{3, 3'd2, 8'h5A, 8'hFF, 8'hA5, 1'b0};
        tbl[9] = '{1, 3'd5, 8'h96, 8'h0F, 8'h99, 1'b0};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_id", 32'(rsp_id), 32'(0));
        chk("rst_rsp_data", 32'(rsp_data), 32'(0));
        chk("rst_rsp_err", 32'(rsp_err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'(0));
            chk("idle_req_ready", 32'(req_ready), 32'(0));
        end

        // Opcode table
        for (int i = 0; i < 10; i++)
            run_txn(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].data, tbl[i].err);

        // Fairness: all four requesters held valid; expect 0,1,2,3,0 every 4 cycles
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            drive_req(i, 3'd0, 8'hFF, 8'(8'h11 * (i + 1)));
        nresp  = 0;
        last_t = -1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (rsp_valid) begin
                exp_id = 2'(nresp % 4);
                chk("fair_id", 32'(rsp_id), 32'(exp_id));
                chk("fair_data", 32'(rsp_data), 32'(8'h11 * (int'(exp_id) + 1)));
                if (last_t >= 0) chk("fair_interval", 32'(k - last_t), 32'(4));
                else             chk("fair_latency", 32'(k), 32'(3));
                last_t = k;
                nresp++;
            end
        end
        req_valid = '0;
        chk("fair_count", 32'(nresp), 32'(5));
        @(negedge clk);
        @(negedge clk);
        chk("fair_drain_busy", 32'(busy), 32'(0));

        // Backpressure: hold response, new request must wait
        rsp_ready = 1'b0;
        drive_req(1, 3'd5, 8'hF0, 8'h3C);
        @(negedge clk);
        chk("bp_req_ready", 32'(req_ready), 32'(4'b0010));
        req_valid[1] = 1'b0;
        drive_req(2, 3'd1, 8'h0F, 8'h30);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
            chk("bp_rsp_id", 32'(rsp_id), 32'(1));
            chk("bp_rsp_data", 32'(rsp_data), 32'(8'hCC));
            chk("bp_req_ready", 32'(req_ready), 32'(0));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(rsp_valid), 32'(0));
        chk("bp_release_ready", 32'(req_ready), 32'(0));
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'(4'b0100));
        req_valid[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_id", 32'(rsp_id), 32'(2));
        chk("bp_next_data", 32'(rsp_data), 32'(8'h3F));
        @(negedge clk);

        // Reset during EXEC: in-flight op to req0 dropped, pending req2 served afterwards
        drive_req(0, 3'd0, 8'hFF, 8'hFF);
        drive_req(2, 3'd1, 8'h0F, 8'h30);
        @(negedge clk);
        chk("rx_grant0", 32'(req_ready), 32'(4'b0001));
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rx_in_exec", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("rx_busy", 32'(busy), 32'(0));
        chk("rx_rsp_valid", 32'(rsp_valid), 32'(0));
        @(negedge clk);
        chk("rx_no_rsp", 32'(rsp_valid), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rx_grant2", 32'(req_ready), 32'(4'b0100));
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("rx_no_rsp_early", 32'(rsp_valid), 32'(0));
        @(negedge clk);
        chk("rx_rsp_valid2", 32'(rsp_valid), 32'(1));
        chk("rx_rsp_id", 32'(rsp_id), 32'(2));
        chk("rx_rsp_data", 32'(rsp_data), 32'(8'h3F));
        @(negedge clk);

        // Pointer restore: after reset, requester 0 wins among all four
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive_req(i, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("ptr_reset_grant", 32'(req_ready), 32'(4'b0001));
        req_valid = '0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
